// File: rtl/dds_wave_gen.sv
// rtl/dds_wave_gen.sv - per-sample DDS waveform generator: phase/LFSR issue, source select, gain, offset, saturate
module dds_wave_gen #(
  parameter int DATA_WIDTH     = 32,
  parameter int WAVE_WIDTH     = 16,
  parameter int LUT_ADDR_WIDTH = 8
) (
  input  logic                         dds_clk_i,
  input  logic                         dds_rst_i,
  input  logic                         enable_i,
  input  logic                         sync_i,
  input  logic [1:0]                   dds_src_i,
  input  logic [DATA_WIDTH-1:0]        tuning_word_i,
  input  logic [DATA_WIDTH-1:0]        gain_word_i,
  input  logic [DATA_WIDTH-1:0]        offset_word_i,
  output logic [LUT_ADDR_WIDTH-1:0]    lut_addr_o,
  input  logic signed [WAVE_WIDTH-1:0] sine_data_i,
  input  logic signed [WAVE_WIDTH-1:0] user_data_i,
  output logic signed [WAVE_WIDTH-1:0] wave_o,
  output logic                         valid_o
);

  localparam int W = WAVE_WIDTH;
  localparam logic [W-1:0] LFSR_SEED = W'(16'hACE1);
  localparam logic [W-1:0] LFSR_TAPS = W'(16'hB400);

  typedef enum logic [1:0] {SRC_SINE = 2'd0, SRC_SAW = 2'd1, SRC_RAND = 2'd2, SRC_USER = 2'd3} src_t;

  logic [DATA_WIDTH-1:0] phase;
  logic [W-1:0]          lfsr;
  logic [W-1:0]          lfsr_next;
  logic                  issue;

  // Per-sample config and source candidates travel down the pipe with the valid tag
  logic                  v1, v2, v3, v4;
  src_t                  src1, src2;
  logic [W-1:0]          gain1, gain2, gain3;
  logic [W-1:0]          off1, off2, off3, off4;
  logic [W-1:0]          saw1, saw2, rnd1, rnd2;
  logic signed [W-1:0]   raw3;
  logic signed [W-1:0]   raw_sel;
  logic signed [W+2:0]   scaled4;

  logic signed [2*W:0]   raw_ext;
  logic signed [2*W:0]   gain_ext;
  logic signed [2*W:0]   prod;
  logic [W+3:0]          sum;
  logic                  ovf;
  logic [W-1:0]          sat;
  logic                  unused_bits;

  assign issue     = enable_i & ~sync_i;
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);

  always_comb begin
    raw_sel = '0;
    case (src2)
      SRC_SINE: raw_sel = sine_data_i;
      SRC_SAW:  raw_sel = $signed(saw2);
      SRC_RAND: raw_sel = $signed(rnd2);
      SRC_USER: raw_sel = user_data_i;
      default:  raw_sel = '0;
    endcase
  end

  // Full-width signed x unsigned product; the slice below is the floor shift by W-2
  assign raw_ext  = {{(W+1){raw3[W-1]}}, raw3};
  assign gain_ext = {{(W+1){1'b0}}, gain3};
  assign prod     = raw_ext * gain_ext;

  assign sum = {scaled4[W+2], scaled4} + {{4{off4[W-1]}}, off4};
  assign ovf = ~((&sum[W+3:W-1]) | ~(|sum[W+3:W-1]));
  assign sat = ovf ? (sum[W+3] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sum[W-1:0];

  assign unused_bits = ^{gain_word_i[DATA_WIDTH-1:W], offset_word_i[DATA_WIDTH-1:W], prod[W-3:0]};

  always_ff @(posedge dds_clk_i or posedge dds_rst_i) begin
    if (dds_rst_i) begin
      phase      <= '0;
      lfsr       <= LFSR_SEED;
      lut_addr_o <= '0;
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      src1 <= SRC_SINE; src2 <= SRC_SINE;
      gain1 <= '0; gain2 <= '0; gain3 <= '0;
      off1 <= '0; off2 <= '0; off3 <= '0; off4 <= '0;
      saw1 <= '0; saw2 <= '0; rnd1 <= '0; rnd2 <= '0;
      raw3    <= '0;
      scaled4 <= '0;
      wave_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      if (sync_i) begin
        phase <= '0;
        lfsr  <= LFSR_SEED;
      end else if (enable_i) begin
        lut_addr_o <= phase[DATA_WIDTH-1 -: LUT_ADDR_WIDTH];
        phase      <= phase + tuning_word_i;
        lfsr       <= lfsr_next;
      end

      v1 <= issue;
      if (issue) begin
        src1  <= src_t'(dds_src_i);
        gain1 <= gain_word_i[W-1:0];
        off1  <= offset_word_i[W-1:0];
        saw1  <= {~phase[DATA_WIDTH-1], phase[DATA_WIDTH-2 -: W-1]};
        rnd1  <= lfsr;
      end

      // Drain stages advance every clock regardless of enable
      v2 <= v1; src2 <= src1; gain2 <= gain1; off2 <= off1; saw2 <= saw1; rnd2 <= rnd1;
      v3 <= v2; raw3 <= raw_sel; gain3 <= gain2; off3 <= off2;
      v4 <= v3; scaled4 <= prod[2*W:W-2]; off4 <= off3;

      valid_o <= v4;
      if (v4) wave_o <= $signed(sat);
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb/tb_dds_wave_gen.sv - directed vectors and reference model for dds_wave_gen
module tb_dds_wave_gen;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               sync = 1'b0;
  logic [1:0]         src = 2'd0;
  logic [31:0]        tw = '0;
  logic [31:0]        gain = '0;
  logic [31:0]        off = '0;
  logic [7:0]         lut_addr;
  logic signed [15:0] sine_data = '0;
  logic signed [15:0] user_data = '0;
  logic signed [15:0] wave;
  logic               valid;

  always #5 clk = ~clk;

  dds_wave_gen #(.DATA_WIDTH(32), .WAVE_WIDTH(16), .LUT_ADDR_WIDTH(8)) dut (
    .dds_clk_i     (clk),
    .dds_rst_i     (rst),
    .enable_i      (enable),
    .sync_i        (sync),
    .dds_src_i     (src),
    .tuning_word_i (tw),
    .gain_word_i   (gain),
    .offset_word_i (off),
    .lut_addr_o    (lut_addr),
    .sine_data_i   (sine_data),
    .user_data_i   (user_data),
    .wave_o        (wave),
    .valid_o       (valid)
  );

  // Sine LUT model with one clock of read latency
  logic signed [15:0] lut [256];
  always @(posedge clk) sine_data <= lut[lut_addr];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          user;
    logic [31:0] gain;
    logic [31:0] off;
    int          expect_wave;
  } vec_t;
  vec_t vecs[10];

  logic [31:0] m_phase;
  logic [15:0] m_lfsr;
  logic [7:0]  m_addr;
  bit          pv[4];
  int          pw[4];
  int          last_wave;
  int          got[$];
  bit          vhist[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int scale(input int raw, input int g, input int o);
    longint p;
    longint s;
    p = longint'(raw) * longint'(g);
    s = (p >>> 14) + longint'(o);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  task automatic model_reset();
    m_phase   = '0;
    m_lfsr    = 16'hACE1;
    m_addr    = '0;
    last_wave = 0;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pw[i] = 0;
    end
  endtask

  task automatic tick();
    bit nv;
    int nw;
    int raw;
    bit ov;
    int ow;
    @(posedge clk);
    nv = 1'b0;
    nw = 0;
    raw = 0;
    if (sync) begin
      m_phase = '0;
      m_lfsr  = 16'hACE1;
    end else if (enable) begin
      case (src)
        2'd0:    raw = int'(lut[m_phase[31:24]]);
        2'd1:    raw = int'($signed({~m_phase[31], m_phase[30:16]}));
        2'd2:    raw = int'($signed(m_lfsr));
        default: raw = int'(user_data);
      endcase
      nw      = scale(raw, int'(gain[15:0]), int'($signed(off[15:0])));
      nv      = 1'b1;
      m_addr  = m_phase[31:24];
      m_phase = m_phase + tw;
      m_lfsr  = lfsr_step(m_lfsr);
    end
    ov = pv[3];
    ow = pw[3];
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pw[i] = pw[i-1];
    end
    pv[0] = nv;
    pw[0] = nw;
    #1;
    chk("valid", int'(valid), int'(ov));
    if (ov) begin
      chk("wave", int'(wave), ow);
      last_wave = ow;
      got.push_back(int'(wave));
    end else begin
      chk("wave_hold", int'(wave), last_wave);
    end
    chk("lut_addr", int'(lut_addr), int'(m_addr));
    vhist.push_back(valid);
  endtask

  initial begin
    int first_one;
    int last_one;
    int zeros;

    for (int i = 0; i < 256; i++) lut[i] = 16'(i * 517 + 12345);
    vecs[0] = '{16384,  32'h0000_8000, 32'h0000_0000,  32767};
    vecs[1] = '{-32768, 32'h0000_4000, 32'h0000_8000, -32768};
    vecs[2] = '{16385,  32'h0000_2000, 32'h0000_0000,   8192};
    vecs[3] = '{-3,     32'h0000_2000, 32'h0000_0000,     -2};
    vecs[4] = '{100,    32'hABCD_4000, 32'h1234_FFCE,     50};
    vecs[5] = '{32767,  32'h0000_FFFF, 32'h0000_0000,  32767};
    vecs[6] = '{-32768, 32'h0000_FFFF, 32'h0000_7FFF, -32768};
    vecs[7] = '{1234,   32'h0000_0000, 32'h0000_FFF9,     -7};
    vecs[8] = '{-100,   32'h0000_6000, 32'h0000_0010,   -134};
    vecs[9] = '{20000,  32'h0000_4000, 32'h0000_31DF,  32767};
    model_reset();

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wave", int'(wave), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_addr", int'(lut_addr), 0);
    rst = 1'b0;
    repeat (20) tick();

    // Sawtooth ramp with wrap, then async reset mid-stream
    src = 2'd1; tw = 32'h0100_0000; gain = 32'h4000; off = '0; enable = 1'b1;
    got.delete();
    for (int e = 0; e < 264; e++) begin
      tick();
      if (e < 3) chk("saw_addr", int'(lut_addr), e);
      if (e <= 4) chk("saw_first_valid", int'(valid), (e == 4) ? 1 : 0);
    end
    chk("saw_count", got.size(), 260);
    if (got.size() >= 257) begin
      chk("saw_s0", got[0], -32768);
      chk("saw_s1", got[1], -32512);
      chk("saw_s2", got[2], -32256);
      chk("saw_s255", got[255], 32512);
      chk("saw_wrap", got[256], -32768);
    end
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_wave", int'(wave), 0);
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_addr", int'(lut_addr), 0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Random source and sync restart (sync wins over enable)
    src = 2'd2; sync = 1'b1; tick(); sync = 1'b0;
    got.delete();
    enable = 1'b1;
    repeat (4) tick();
    sync = 1'b1; tick(); sync = 1'b0;
    tick();
    enable = 1'b0;
    repeat (5) tick();
    chk("rnd_count", got.size(), 5);
    if (got.size() == 5) begin
      chk("rnd_0", got[0], -21279);
      chk("rnd_1", got[1], -7568);
      chk("rnd_2", got[2], 28984);
      chk("rnd_3", got[3], 14492);
      chk("rnd_resync", got[4], -21279);
    end

    // User source gain/offset/saturation table
    src = 2'd3;
    foreach (vecs[i]) begin
      user_data = 16'(vecs[i].user);
      gain      = vecs[i].gain;
      off       = vecs[i].off;
      enable    = 1'b1;
      tick();
      enable = 1'b0;
      repeat (4) tick();
      chk("vec_valid", int'(valid), 1);
      chk("vec_wave", int'(wave), vecs[i].expect_wave);
    end

    // Sine source, tuning all-ones: address walks down from 0x00 to 0xFF
    src = 2'd0; tw = 32'hFFFF_FFFF; gain = 32'h4000; off = '0;
    sync = 1'b1; tick(); sync = 1'b0;
    enable = 1'b1;
    tick(); chk("sine_addr0", int'(lut_addr), 8'h00);
    tick(); chk("sine_addr1", int'(lut_addr), 8'hFF);
    tick(); chk("sine_addr2", int'(lut_addr), 8'hFF);
    enable = 1'b0;
    repeat (5) tick();

    // Enable gap of 3 clocks with a coarse tuning so every phase step is visible
    tw = 32'hFF00_0000;
    sync = 1'b1; tick(); sync = 1'b0;
    got.delete(); vhist.delete();
    enable = 1'b1; repeat (6) tick();
    enable = 1'b0; repeat (3) tick();
    enable = 1'b1; repeat (4) tick();
    enable = 1'b0; repeat (6) tick();
    chk("gap_count", got.size(), 10);
    for (int i = 0; i < got.size(); i++) chk("gap_sample", got[i], int'(lut[(256 - i) & 255]));
    first_one = -1; last_one = -1; zeros = 0;
    for (int i = 0; i < vhist.size(); i++) begin
      if (vhist[i]) begin
        if (first_one < 0) first_one = i;
        last_one = i;
      end
    end
    for (int i = first_one; i <= last_one && first_one >= 0; i++) if (!vhist[i]) zeros++;
    chk("gap_valid_low", zeros, 3);

    // Source switch between issue edges affects only later samples
    src = 2'd1; tw = 32'h0100_0000; gain = 32'h4000; off = '0;
    sync = 1'b1; enable = 1'b1; tick(); sync = 1'b0;
    got.delete();
    tick(); tick();
    src = 2'd2; tick();
    enable = 1'b0;
    repeat (5) tick();
    chk("switch_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("switch_saw0", got[0], -32768);
      chk("switch_saw1", got[1], -32512);
      chk("switch_rnd", got[2], 28984);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
